udp_axis_rx_mux: RTL and testbench

- Multi-channel UDP receive endpoint. Accepts datagrams from the UDP stack on NUM_CHANNELS consecutive ports starting at UDP_PORT_BASE.
- For each accepted datagram it strips a leading transfer ID of ID_BYTES bytes and forwards the remaining payload on one AXI-Stream output, tagged with the channel index in tdest.
- After the datagram ends it returns an acknowledgement datagram to the sender: the echoed ID followed by one status byte.
- Sits between the UDP stack (rx/tx header and payload interfaces) and the downstream channel demux or FIFOs.

---
 rtl/udp_axis_rx_mux_pkg.sv | 26 ++
 rtl/udp_axis_rx_mux_if.sv | 48 ++++
 rtl/udp_axis_rx_mux_ack_tx.sv | 121 ++++++++++++
 rtl/udp_axis_rx_mux.sv | 156 +++++++++++++++
 tb/tb_udp_axis_rx_mux.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_axis_rx_mux_pkg.sv
// Shared types and constants for the multi-channel UDP receive mux and its ack transmitter.
package udp_axis_pkg;

    typedef enum logic [2:0] {
        RX_HEADER,
        RX_DISCARD,
        RX_ID,
        RX_DATA,
        ACK_WAIT
    } state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_HEADER,
        TX_ID,
        TX_STATUS
    } tx_state_t;

    localparam logic [7:0] ACK_OK    = 8'h00;
    localparam logic [7:0] ACK_SHORT = 8'h01;
    localparam logic [7:0] ACK_ERR   = 8'h02;
    localparam logic [7:0] ACK_EMPTY = 8'h03;

    localparam int UDP_HDR_LEN = 8;

endpackage

// File: rtl/udp_axis_rx_mux_if.sv
// UDP header and AXI-Stream bundles used between the UDP stack, the rx mux and downstream.
interface UDP_RX_HEADER_IF;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;

    modport Source (output hdr_valid, src_ip, dst_ip, src_port, dst_port, length, input hdr_ready);
    modport Sink   (input hdr_valid, src_ip, dst_ip, src_port, dst_port, length, output hdr_ready);
endinterface

interface UDP_TX_HEADER_IF;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [7:0]  ttl;
    logic [15:0] length;
    logic [15:0] checksum;

    modport Source (output hdr_valid, src_ip, dst_ip, src_port, dst_port, dscp, ecn, ttl, length,
                    checksum, input hdr_ready);
    modport Sink   (input hdr_valid, src_ip, dst_ip, src_port, dst_port, dscp, ecn, ttl, length,
                    checksum, output hdr_ready);
endinterface

interface AXIS_IF #(
    parameter int DATA_WIDTH  = 8,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0]  tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TUSER_WIDTH-1:0] tuser;

    modport Transmitter (output tdata, tvalid, tlast, tdest, tuser, input tready);
    modport Receiver    (input tdata, tvalid, tlast, tdest, tuser, output tready);
endinterface

// File: rtl/udp_axis_rx_mux_ack_tx.sv
// Serialises one acknowledgement datagram: swapped header, then the echoed ID bytes and a status byte.
module udp_ack_tx
    import udp_axis_pkg::*;
#(
    parameter int ID_BYTES = 6,
    parameter int ACK_TTL  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           local_ip,
    input  logic [31:0]           peer_ip,
    input  logic [15:0]           local_port,
    input  logic [15:0]           peer_port,
    input  logic [8*ID_BYTES-1:0] id,
    input  logic [7:0]            status,
    output logic                  busy,
    UDP_TX_HEADER_IF.Source       tx_hdr,
    AXIS_IF.Transmitter           tx_payload
);

    localparam int IDX_W = (ID_BYTES > 1) ? $clog2(ID_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ID_BYTES - 1);

    tx_state_t             state;
    logic                  hdr_valid;
    logic                  tvalid;
    logic                  tlast;
    logic [7:0]            tdata;
    logic [8*ID_BYTES-1:0] id_sh;
    logic [7:0]            status_r;
    logic [IDX_W-1:0]      cnt;
    logic [31:0]           src_ip_r;
    logic [31:0]           dst_ip_r;
    logic [15:0]           src_port_r;
    logic [15:0]           dst_port_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= TX_IDLE;
            hdr_valid  <= 1'b0;
            tvalid     <= 1'b0;
            tlast      <= 1'b0;
            tdata      <= '0;
            id_sh      <= '0;
            status_r   <= ACK_OK;
            cnt        <= '0;
            src_ip_r   <= '0;
            dst_ip_r   <= '0;
            src_port_r <= '0;
            dst_port_r <= '0;
        end else begin
            unique case (state)
                TX_IDLE: begin
                    if (start) begin
                        src_ip_r   <= local_ip;
                        dst_ip_r   <= peer_ip;
                        src_port_r <= local_port;
                        dst_port_r <= peer_port;
                        id_sh      <= id;
                        status_r   <= status;
                        hdr_valid  <= 1'b1;
                        state      <= TX_HEADER;
                    end
                end
                TX_HEADER: begin
                    if (tx_hdr.hdr_ready) begin
                        hdr_valid <= 1'b0;
                        tvalid    <= 1'b1;
                        tdata     <= id_sh[7:0];
                        id_sh     <= id_sh >> 8;
                        cnt       <= '0;
                        state     <= TX_ID;
                    end
                end
                TX_ID: begin
                    if (tx_payload.tready) begin
                        if (cnt == LAST_IDX) begin
                            tdata <= status_r;
                            tlast <= 1'b1;
                            state <= TX_STATUS;
                        end else begin
                            tdata <= id_sh[7:0];
                            id_sh <= id_sh >> 8;
                            cnt   <= cnt + IDX_W'(1);
                        end
                    end
                end
                TX_STATUS: begin
                    if (tx_payload.tready) begin
                        tvalid <= 1'b0;
                        tlast  <= 1'b0;
                        state  <= TX_IDLE;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    // Busy drops in the cycle the status byte is taken so the rx side can re-arm without a bubble.
    assign busy = (state != TX_IDLE) && !((state == TX_STATUS) && tx_payload.tready);

    assign tx_hdr.hdr_valid = hdr_valid;
    assign tx_hdr.src_ip    = src_ip_r;
    assign tx_hdr.dst_ip    = dst_ip_r;
    assign tx_hdr.src_port  = src_port_r;
    assign tx_hdr.dst_port  = dst_port_r;
    assign tx_hdr.dscp      = '0;
    assign tx_hdr.ecn       = '0;
    assign tx_hdr.ttl       = 8'(ACK_TTL);
    assign tx_hdr.length    = 16'(UDP_HDR_LEN + ID_BYTES + 1);
    assign tx_hdr.checksum  = '0;

    assign tx_payload.tvalid = tvalid;
    assign tx_payload.tdata  = tdata;
    assign tx_payload.tlast  = tlast;
    assign tx_payload.tdest  = '0;
    assign tx_payload.tuser  = '0;

endmodule

// File: rtl/udp_axis_rx_mux.sv
// Multi-channel UDP receive endpoint: strips a transfer ID, forwards payload tagged by channel, acks the sender.
module udp_axis_rx_mux
    import udp_axis_pkg::*;
#(
    parameter int UDP_PORT_BASE = 4321,
    parameter int NUM_CHANNELS  = 4,
    parameter int ID_BYTES      = 6,
    parameter int ACK_TTL       = 64
) (
    input  logic            clk,
    input  logic            reset,
    UDP_RX_HEADER_IF.Sink   udp_rx_header_if,
    AXIS_IF.Receiver        udp_rx_payload_if,
    UDP_TX_HEADER_IF.Source udp_tx_header_if,
    AXIS_IF.Transmitter     udp_tx_payload_if,
    AXIS_IF.Transmitter     out_axis_if,
    output logic [31:0]     rx_count,
    output logic [31:0]     drop_count
);

    localparam int DEST_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int IDX_W  = (ID_BYTES > 1) ? $clog2(ID_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ID_BYTES - 1);

    state_t                state;
    logic                  hdr_ready;
    logic                  ack_start;
    logic                  ack_busy;
    logic [IDX_W-1:0]      idx;
    logic [8*ID_BYTES-1:0] id;
    logic [7:0]            status;
    logic [DEST_W-1:0]     ch;
    logic [31:0]           peer_ip;
    logic [31:0]           local_ip;
    logic [15:0]           peer_port;
    logic [15:0]           local_port;
    logic [15:0]           ch_full;
    logic                  rx_beat;

    // Ports below the base wrap to large values and fall outside the channel range.
    assign ch_full = udp_rx_header_if.dst_port - 16'(UDP_PORT_BASE);
    assign rx_beat = udp_rx_payload_if.tvalid && udp_rx_payload_if.tready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RX_HEADER;
            hdr_ready  <= 1'b0;
            ack_start  <= 1'b0;
            idx        <= '0;
            id         <= '0;
            status     <= ACK_OK;
            ch         <= '0;
            peer_ip    <= '0;
            local_ip   <= '0;
            peer_port  <= '0;
            local_port <= '0;
            rx_count   <= '0;
            drop_count <= '0;
        end else begin
            ack_start <= 1'b0;
            unique case (state)
                RX_HEADER: begin
                    hdr_ready <= 1'b1;
                    if (hdr_ready && udp_rx_header_if.hdr_valid) begin
                        hdr_ready  <= 1'b0;
                        peer_ip    <= udp_rx_header_if.src_ip;
                        local_ip   <= udp_rx_header_if.dst_ip;
                        peer_port  <= udp_rx_header_if.src_port;
                        local_port <= udp_rx_header_if.dst_port;
                        idx        <= '0;
                        id         <= '0;
                        if (ch_full < 16'(NUM_CHANNELS)) begin
                            ch       <= ch_full[DEST_W-1:0];
                            rx_count <= rx_count + 32'd1;
                            state    <= RX_ID;
                        end else begin
                            drop_count <= drop_count + 32'd1;
                            state      <= RX_DISCARD;
                        end
                    end
                end
                RX_DISCARD: begin
                    if (rx_beat && udp_rx_payload_if.tlast) begin
                        hdr_ready <= 1'b1;
                        state     <= RX_HEADER;
                    end
                end
                RX_ID: begin
                    if (rx_beat) begin
                        id[{idx, 3'b000} +: 8] <= udp_rx_payload_if.tdata;
                        if (udp_rx_payload_if.tlast) begin
                            status    <= (idx == LAST_IDX) ? ACK_EMPTY : ACK_SHORT;
                            ack_start <= 1'b1;
                            state     <= ACK_WAIT;
                        end else if (idx == LAST_IDX) begin
                            state <= RX_DATA;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_beat && udp_rx_payload_if.tlast) begin
                        status    <= udp_rx_payload_if.tuser[0] ? ACK_ERR : ACK_OK;
                        ack_start <= 1'b1;
                        state     <= ACK_WAIT;
                    end
                end
                ACK_WAIT: begin
                    // ack_start is still pending in the first cycle, before busy has risen.
                    if (!ack_start && !ack_busy) begin
                        hdr_ready <= 1'b1;
                        state     <= RX_HEADER;
                    end
                end
                default: state <= RX_HEADER;
            endcase
        end
    end

    always_comb begin
        udp_rx_payload_if.tready = 1'b0;
        unique case (state)
            RX_DISCARD, RX_ID: udp_rx_payload_if.tready = 1'b1;
            RX_DATA:           udp_rx_payload_if.tready = out_axis_if.tready;
            default:           udp_rx_payload_if.tready = 1'b0;
        endcase
    end

    assign udp_rx_header_if.hdr_ready = hdr_ready;

    assign out_axis_if.tvalid = (state == RX_DATA) && udp_rx_payload_if.tvalid;
    assign out_axis_if.tdata  = udp_rx_payload_if.tdata;
    assign out_axis_if.tlast  = udp_rx_payload_if.tlast;
    assign out_axis_if.tuser  = udp_rx_payload_if.tuser;
    assign out_axis_if.tdest  = ch;

    udp_ack_tx #(
        .ID_BYTES (ID_BYTES),
        .ACK_TTL  (ACK_TTL)
    ) u_ack_tx (
        .clk        (clk),
        .reset      (reset),
        .start      (ack_start),
        .local_ip   (local_ip),
        .peer_ip    (peer_ip),
        .local_port (local_port),
        .peer_port  (peer_port),
        .id         (id),
        .status     (status),
        .busy       (ack_busy),
        .tx_hdr     (udp_tx_header_if),
        .tx_payload (udp_tx_payload_if)
    );

endmodule

// File: tb/tb_udp_axis_rx_mux.sv
// Randomised scoreboard bench for udp_axis_rx_mux: packet-level model feeds queues, monitors pop and compare.
module tb_udp_axis_rx_mux;

    localparam int BASE = 4321;
    localparam int NCH  = 4;
    localparam int IDB  = 6;
    localparam int TTL  = 64;
    localparam int DW   = 2;

    typedef logic [7:0] bytes_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rx_count;
    logic [31:0] drop_count;

    always #5 clk = ~clk;

    UDP_RX_HEADER_IF rx_hdr ();
    UDP_TX_HEADER_IF tx_hdr ();
    AXIS_IF #(.DATA_WIDTH(8), .TDEST_WIDTH(1), .TUSER_WIDTH(1)) rx_pl ();
    AXIS_IF #(.DATA_WIDTH(8), .TDEST_WIDTH(1), .TUSER_WIDTH(1)) tx_pl ();
    AXIS_IF #(.DATA_WIDTH(8), .TDEST_WIDTH(DW), .TUSER_WIDTH(1)) out_if ();

    udp_axis_rx_mux #(
        .UDP_PORT_BASE (BASE),
        .NUM_CHANNELS  (NCH),
        .ID_BYTES      (IDB),
        .ACK_TTL       (TTL)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .udp_rx_header_if  (rx_hdr),
        .udp_rx_payload_if (rx_pl),
        .udp_tx_header_if  (tx_hdr),
        .udp_tx_payload_if (tx_pl),
        .out_axis_if       (out_if),
        .rx_count          (rx_count),
        .drop_count        (drop_count)
    );

    int checks = 0;
    int passed = 0;
    int rx_exp = 0;
    int drop_exp = 0;
    int out_lasts_seen = 0;
    int out_lasts_exp = 0;
    bit rand_ready = 1'b0;

    logic [11:0]  exp_out[$];      // {dest, user, last, data}
    logic [159:0] exp_hdr[$];
    int           exp_hdr_lasts[$];
    logic [8:0]   exp_ack[$];      // {last, data}

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Packet-level reference: what the endpoint must emit for one datagram.
    task automatic model(input logic [15:0] port, input logic [31:0] sip, input logic [31:0] dip,
                         input logic [15:0] sport, input bytes_t b, input logic tuser_last);
        logic [15:0] ch;
        logic [7:0]  st;
        int          n;
        ch = port - 16'(BASE);
        if (int'(ch) >= NCH) begin
            drop_exp++;
            return;
        end
        rx_exp++;
        n = b.size();
        for (int k = IDB; k < n; k++)
            exp_out.push_back({ch[DW-1:0], (k == n - 1) ? tuser_last : 1'b0, k == n - 1, b[k]});
        if (n > IDB) out_lasts_exp++;
        if (n < IDB)       st = 8'h01;
        else if (n == IDB) st = 8'h03;
        else               st = tuser_last ? 8'h02 : 8'h00;
        exp_hdr.push_back({16'd0, dip, sip, port, sport, 6'd0, 2'd0, 8'(TTL), 16'(8 + IDB + 1), 16'd0});
        exp_hdr_lasts.push_back(out_lasts_exp);
        for (int k = 0; k < IDB; k++)
            exp_ack.push_back({1'b0, (k < n) ? b[k] : 8'h00});
        exp_ack.push_back({1'b1, st});
    endtask

    task automatic send_hdr(input logic [15:0] port, input logic [31:0] sip, input logic [31:0] dip,
                            input logic [15:0] sport);
        bit hs = 1'b0;
        rx_hdr.src_ip    = sip;
        rx_hdr.dst_ip    = dip;
        rx_hdr.src_port  = sport;
        rx_hdr.dst_port  = port;
        rx_hdr.length    = 16'd0;
        rx_hdr.hdr_valid = 1'b1;
        for (int c = 0; c < 1000 && !hs; c++) begin
            @(negedge clk);
            hs = rx_hdr.hdr_ready;
            @(posedge clk);
            #1;
        end
        rx_hdr.hdr_valid = 1'b0;
        if (!hs) fail_now("rx_hdr_timeout", "hdr_ready never seen, required 1");
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic user, input bit gaps);
        bit hs = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        rx_pl.tdata  = d;
        rx_pl.tlast  = last;
        rx_pl.tuser  = user;
        rx_pl.tvalid = 1'b1;
        for (int c = 0; c < 1000 && !hs; c++) begin
            @(negedge clk);
            hs = rx_pl.tready;
            @(posedge clk);
            #1;
        end
        rx_pl.tvalid = 1'b0;
        rx_pl.tlast  = 1'b0;
        rx_pl.tuser  = 1'b0;
        if (!hs) fail_now("rx_beat_timeout", "rx tready never seen, required 1");
    endtask

    task automatic send_pkt(input logic [15:0] port, input bytes_t b, input logic tuser_last, input bit gaps);
        logic [31:0] sip;
        logic [31:0] dip;
        logic [15:0] sport;
        sip   = $urandom;
        dip   = $urandom;
        sport = 16'($urandom);
        model(port, sip, dip, sport, b, tuser_last);
        send_hdr(port, sip, dip, sport);
        for (int k = 0; k < b.size(); k++)
            send_beat(b[k], k == b.size() - 1, (k == b.size() - 1) ? tuser_last : 1'b0, gaps);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(posedge clk);
            #1;
            done = (exp_out.size() == 0) && (exp_hdr.size() == 0) && (exp_ack.size() == 0);
        end
        repeat (4) begin @(posedge clk); #1; end
        if (!done) fail_now("drain_timeout", "expected output still pending, required none");
    endtask

    initial begin
        out_if.tready  = 1'b0;
        tx_hdr.hdr_ready = 1'b0;
        tx_pl.tready   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_if.tready    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tx_hdr.hdr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tx_pl.tready     = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic [159:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (out_if.tvalid && out_if.tready) begin
                    if (exp_out.size() == 0) begin
                        fail_now("out_unexpected", $sformatf("beat %0h appeared, required none",
                                 out_if.tdata));
                    end else begin
                        e = 160'(exp_out.pop_front());
                        check("out_beat", 160'({out_if.tdest, out_if.tuser, out_if.tlast, out_if.tdata}), e);
                    end
                    if (out_if.tlast) out_lasts_seen++;
                end
                if (tx_hdr.hdr_valid && tx_hdr.hdr_ready) begin
                    if (exp_hdr.size() == 0) begin
                        fail_now("ack_hdr_unexpected", "ack header appeared, required none");
                    end else begin
                        e = exp_hdr.pop_front();
                        check("ack_hdr", 160'({tx_hdr.src_ip, tx_hdr.dst_ip, tx_hdr.src_port,
                              tx_hdr.dst_port, tx_hdr.dscp, tx_hdr.ecn, tx_hdr.ttl, tx_hdr.length,
                              tx_hdr.checksum}), e);
                        check("ack_after_data", 160'(out_lasts_seen >= exp_hdr_lasts.pop_front()), 160'd1);
                    end
                end
                if (tx_pl.tvalid && tx_pl.tready) begin
                    if (exp_ack.size() == 0) begin
                        fail_now("ack_byte_unexpected", $sformatf("byte %0h appeared, required none",
                                 tx_pl.tdata));
                    end else begin
                        e = 160'(exp_ack.pop_front());
                        check("ack_byte", 160'({tx_pl.tlast, tx_pl.tdata}), e);
                    end
                end
            end
        end
    end

    initial begin
        bytes_t b;
        logic [15:0] port;
        int r;

        rx_hdr.hdr_valid = 1'b0;
        rx_hdr.src_ip = '0; rx_hdr.dst_ip = '0; rx_hdr.src_port = '0; rx_hdr.dst_port = '0;
        rx_hdr.length = '0;
        rx_pl.tvalid = 1'b0; rx_pl.tdata = '0; rx_pl.tlast = 1'b0; rx_pl.tuser = '0; rx_pl.tdest = '0;

        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("reset_hdr_ready", 160'(rx_hdr.hdr_ready), 160'd0);
        check("reset_tx_hdr_valid", 160'(tx_hdr.hdr_valid), 160'd0);
        check("reset_tx_tvalid", 160'({tx_pl.tvalid, tx_pl.tlast, tx_pl.tuser}), 160'd0);
        check("reset_out_tvalid", 160'(out_if.tvalid), 160'd0);
        check("reset_counters", 160'({rx_count, drop_count}), 160'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hAA, 8'hBB, 8'hCC};
        send_pkt(16'd4322, b, 1'b0, 1'b0);
        b = {};
        for (int k = 0; k < 20; k++) b.push_back(8'(k + 8'h40));
        send_pkt(16'd4000, b, 1'b0, 1'b0);
        b = '{8'h11, 8'h22, 8'h33};
        send_pkt(16'd4321, b, 1'b0, 1'b0);
        b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        send_pkt(16'd4321, b, 1'b0, 1'b0);
        b = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'h77, 8'h88};
        send_pkt(16'd4324, b, 1'b1, 1'b0);
        drain();
        check("directed_rx_count", 160'(rx_count), 160'(rx_exp));
        check("directed_drop_count", 160'(drop_count), 160'(drop_exp));

        rand_ready = 1'b1;
        for (int p = 0; p < 100; p++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       port = 16'(BASE + $urandom_range(0, NCH - 1));
            else if (r == 7) port = 16'(BASE - $urandom_range(1, 400));
            else             port = 16'(BASE + NCH + $urandom_range(0, 1000));
            b = {};
            for (int k = 0; k < $urandom_range(1, 16); k++) b.push_back(8'($urandom));
            send_pkt(port, b, ($urandom_range(0, 3) == 0), 1'b1);
        end
        drain();
        check("random_rx_count", 160'(rx_count), 160'(rx_exp));
        check("random_drop_count", 160'(drop_count), 160'(drop_exp));

        // Reset while data is streaming on channel 2.
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        send_hdr(16'd4323, 32'h0A000001, 32'h0A000002, 16'd5000);
        for (int k = 0; k < IDB; k++) send_beat(8'(k + 1), 1'b0, 1'b0, 1'b0);
        exp_out.push_back({2'd2, 1'b0, 1'b0, 8'h5A});
        send_beat(8'h5A, 1'b0, 1'b0, 1'b0);
        exp_out.push_back({2'd2, 1'b0, 1'b0, 8'h5B});
        send_beat(8'h5B, 1'b0, 1'b0, 1'b0);
        rx_pl.tdata  = 8'h5C;
        rx_pl.tvalid = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_hdr_ready", 160'(rx_hdr.hdr_ready), 160'd0);
        check("midreset_out_tvalid", 160'(out_if.tvalid), 160'd0);
        check("midreset_tx_valids", 160'({tx_hdr.hdr_valid, tx_pl.tvalid, tx_pl.tlast}), 160'd0);
        check("midreset_counters", 160'({rx_count, drop_count}), 160'd0);
        check("midreset_forwarded", 160'(exp_out.size()), 160'd0);
        @(posedge clk);
        #1;
        rx_pl.tvalid = 1'b0;
        reset = 1'b0;
        rx_exp = 0;
        drop_exp = 0;

        b = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hD0, 8'hD1, 8'hD2};
        send_pkt(16'd4323, b, 1'b0, 1'b0);
        drain();
        check("post_reset_rx_count", 160'(rx_count), 160'(rx_exp));
        check("post_reset_drop_count", 160'(drop_count), 160'(drop_exp));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
